// File: rtl/audio_synth_pkg.sv
// audio_synth_pkg: shared FSM states, widths and per-voice reset defaults for the additive voice sequencer
package audio_synth_pkg;
  localparam int NVOICE = 4;
  localparam int LUT_AW = 8;
  localparam int LUT_DW = 16;
  localparam int ACC_W = 21;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ACC, DONE} state_t;
  function automatic logic [15:0] def_inc(int v);
    return 16'(16'h0100 * (v + 1));
  endfunction
  function automatic logic [2:0] def_gain(int v);
    return v == 0 ? 3'd6 : v == 1 ? 3'd3 : v == 2 ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/voice_sequencer_if.sv
// voice_sequencer_if: configuration write bus (voice select, phase increment, gain)
interface voice_sequencer_if;
  logic cfg_we;
  logic [1:0] cfg_sel;
  logic [15:0] cfg_inc;
  logic [2:0] cfg_gain;
  modport master (output cfg_we, cfg_sel, cfg_inc, cfg_gain);
  modport slave (input cfg_we, cfg_sel, cfg_inc, cfg_gain);
endinterface

// File: rtl/voice_regfile.sv
// voice_regfile: per-voice increment, gain and phase registers with a write port and a phase-advance port
module voice_regfile #(
  parameter int NVOICE = audio_synth_pkg::NVOICE,
  parameter int PHASE_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [1:0] wsel,
  input  logic [15:0] winc,
  input  logic [2:0] wgain,
  input  logic adv,
  input  logic [1:0] asel,
  output logic [2:0] gain,
  output logic [audio_synth_pkg::LUT_AW-1:0] addr
);
  import audio_synth_pkg::*;
  logic [15:0] inc_q [NVOICE];
  logic [15:0] inc_d [NVOICE];
  logic [2:0] gain_q [NVOICE];
  logic [2:0] gain_d [NVOICE];
  logic [PHASE_W-1:0] phase_q [NVOICE];
  logic [PHASE_W-1:0] phase_d [NVOICE];
  assign gain = gain_q[asel];
  assign addr = phase_q[asel][PHASE_W-1 -: LUT_AW];
  // advance reads inc_q, so a write on the same edge only affects later advances
  always_comb begin
    inc_d = inc_q;
    gain_d = gain_q;
    phase_d = phase_q;
    if (adv) phase_d[asel] = phase_q[asel] + PHASE_W'(inc_q[asel]);
    if (we) begin
      inc_d[wsel] = winc;
      gain_d[wsel] = wgain;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NVOICE; i++) begin
        inc_q[i] <= def_inc(i);
        gain_q[i] <= def_gain(i);
        phase_q[i] <= '0;
      end
    end else begin
      inc_q <= inc_d;
      gain_q <= gain_d;
      phase_q <= phase_d;
    end
  end
endmodule

// File: rtl/voice_sequencer.sv
// voice_sequencer: time-multiplexed additive mixer over one sine LUT; VOICE_SEQ_SATURATE_EN clamps mix_out instead of wrapping
module voice_sequencer #(
  parameter int NVOICE = audio_synth_pkg::NVOICE,
  parameter int PHASE_W = 16,
  parameter int MIX_SHIFT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  voice_sequencer_if.slave cfg,
  output logic [7:0] lut_addr,
  input  logic [15:0] lut_data,
  output logic [15:0] mix_out,
  output logic mix_valid,
  output logic busy,
  output logic overrun
);
  import audio_synth_pkg::*;
  state_t state_q, state_d;
  logic [1:0] v_q, v_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LUT_AW-1:0] lut_addr_q, lut_addr_d, addr;
  logic [15:0] mix_out_q, mix_out_d, mix_next;
  logic mix_valid_q, mix_valid_d, overrun_q, overrun_d, adv;
  logic [2:0] gain;
  voice_regfile #(.NVOICE(NVOICE), .PHASE_W(PHASE_W)) u_regs (
    .clk, .rst, .we(cfg.cfg_we), .wsel(cfg.cfg_sel), .winc(cfg.cfg_inc), .wgain(cfg.cfg_gain),
    .adv, .asel(v_q), .gain, .addr
  );
`ifdef VOICE_SEQ_SATURATE_EN
  logic [ACC_W-1:0] shifted;
  assign shifted = acc_q >> MIX_SHIFT;
  assign mix_next = |shifted[ACC_W-1:16] ? 16'hFFFF : shifted[15:0];
`else
  assign mix_next = 16'(acc_q >> MIX_SHIFT);
`endif
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    acc_d = acc_q;
    lut_addr_d = lut_addr_q;
    mix_out_d = mix_out_q;
    mix_valid_d = 1'b0;
    overrun_d = overrun_q | (sample_tick & (state_q != IDLE));
    adv = 1'b0;
    case (state_q)
      IDLE: if (sample_tick) begin
        acc_d = '0;
        v_d = '0;
        state_d = FETCH;
      end
      FETCH: begin
        lut_addr_d = addr;
        state_d = WAIT;
      end
      WAIT: state_d = ACC;
      ACC: begin
        acc_d = acc_q + ACC_W'(lut_data) * ACC_W'(gain);
        adv = 1'b1;
        v_d = v_q == 2'(NVOICE - 1) ? v_q : v_q + 2'd1;
        state_d = v_q == 2'(NVOICE - 1) ? DONE : FETCH;
      end
      DONE: begin
        mix_out_d = mix_next;
        mix_valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q <= '0;
      acc_q <= '0;
      lut_addr_q <= '0;
      mix_out_q <= '0;
      mix_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      acc_q <= acc_d;
      lut_addr_q <= lut_addr_d;
      mix_out_q <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign lut_addr = lut_addr_q;
  assign mix_out = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy = state_q != IDLE;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_voice_sequencer.sv
// tb_voice_sequencer: directed table, corner sequences and randomized samples against a sum-of-voices reference model
module tb_voice_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  logic [7:0] lut_addr;
  logic [15:0] lut_data, mix_out;
  logic mix_valid, busy, overrun;
  int rom_mode = 0;
  int compared = 0;
  int mismatched = 0;
  logic [15:0] m_phase [4];
  logic [15:0] m_inc [4];
  logic [2:0] m_gain [4];
  voice_sequencer_if cfg ();
  voice_sequencer dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .cfg(cfg),
    .lut_addr(lut_addr), .lut_data(lut_data), .mix_out(mix_out),
    .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] rom(int m, logic [7:0] a);
    return m == 0 ? {a, 8'h00} : m == 1 ? 16'hFFFF : {a ^ 8'hA5, ~a};
  endfunction
  assign lut_data = rom(rom_mode, lut_addr);
  task automatic chk(string n, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_phase[i] = 16'h0;
      m_inc[i] = 16'(16'h0100 * (i + 1));
    end
    m_gain[0] = 3'd6; m_gain[1] = 3'd3; m_gain[2] = 3'd2; m_gain[3] = 3'd1;
  endtask
  // sum of rom(phase>>8)*gain over voices, then shift and clamp/wrap
  task automatic model_sample(output logic [15:0] mix, output logic [3:0][7:0] a);
    int sum, sh;
    sum = 0;
    for (int v = 0; v < 4; v++) begin
      a[v] = m_phase[v][15:8];
      sum += int'(rom(rom_mode, a[v])) * int'(m_gain[v]);
      m_phase[v] = m_phase[v] + m_inc[v];
    end
    sh = sum / 4;
`ifdef VOICE_SEQ_SATURATE_EN
    mix = sh > 65535 ? 16'hFFFF : 16'(sh);
`else
    mix = 16'(sh);
`endif
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_tick = 1'b0;
    cfg.cfg_we = 1'b0; cfg.cfg_sel = 2'd0; cfg.cfg_inc = 16'h0; cfg.cfg_gain = 3'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask
  task automatic cfg_write(logic [1:0] sel, logic [15:0] inc, logic [2:0] gain);
    @(negedge clk);
    cfg.cfg_we = 1'b1; cfg.cfg_sel = sel; cfg.cfg_inc = inc; cfg.cfg_gain = gain;
    @(negedge clk);
    cfg.cfg_we = 1'b0;
    m_inc[sel] = inc;
    m_gain[sel] = gain;
  endtask
  // n counts clock edges after the one that sampled the tick
  task automatic do_sample(output int lat, output logic [15:0] mix, output logic [3:0][7:0] a, output logic b0);
    @(negedge clk);
    sample_tick = 1'b1;
    lat = -1; mix = 16'h0; a = '0; b0 = 1'b0;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      if (n == 0) b0 = busy;
      if (n % 3 == 2 && n <= 11) a[(n - 2) / 3] = lut_addr;
      if (mix_valid) begin
        lat = n;
        mix = mix_out;
        break;
      end
    end
  endtask
  task automatic run_check(string tag, logic [15:0] emix, logic [3:0][7:0] ea);
    int lat;
    logic [15:0] mix;
    logic [3:0][7:0] a;
    logic b0;
    do_sample(lat, mix, a, b0);
    chk({tag, "_latency"}, lat, 13);
    chk({tag, "_busy"}, int'(b0), 1);
    chk({tag, "_addrs"}, int'(a), int'(ea));
    chk({tag, "_mix"}, int'(mix), int'(emix));
    @(negedge clk);
    chk({tag, "_valid_1cyc"}, int'(mix_valid), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask
  typedef struct {
    int rom;
    logic [15:0] mix;
    logic [31:0] a;
  } vec_t;
  vec_t tbl [3];
  initial begin
    logic [15:0] em;
    logic [3:0][7:0] ea;
    int lat, pulses, first;
    logic [15:0] mix;
    logic [3:0][7:0] a;
    logic b0;
    logic [7:0] e42 [3];
    tbl[0] = '{0, 16'h0000, 32'h00000000};
    tbl[1] = '{0, 16'h0580, 32'h04030201};
    tbl[2] = '{0, 16'h0B00, 32'h08060402};
    do_reset();
    chk("rst_lut_addr", int'(lut_addr), 0);
    chk("rst_mix_out", int'(mix_out), 0);
    chk("rst_mix_valid", int'(mix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    for (int i = 0; i < 3; i++) begin
      rom_mode = tbl[i].rom;
      run_check($sformatf("table%0d", i), tbl[i].mix, tbl[i].a);
    end
    for (int i = 0; i < 4; i++) cfg_write(2'(i), 16'(16'h0100 * (i + 1)), 3'd7);
    rom_mode = 1;
`ifdef VOICE_SEQ_SATURATE_EN
    run_check("saturate", 16'hFFFF, 32'h0C090603);
`else
    run_check("saturate", 16'hFFF9, 32'h0C090603);
`endif
    rom_mode = 0;
    do_reset();
    @(negedge clk);
    sample_tick = 1'b1;
    pulses = 0; first = -1;
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      sample_tick = (n == 4);
      if (mix_valid) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    chk("overrun_pulses", pulses, 1);
    chk("overrun_latency", first, 13);
    chk("overrun_set", int'(overrun), 1);
    model_sample(em, ea);
    model_sample(em, ea);
    run_check("after_overrun", em, ea);
    chk("overrun_sticky", int'(overrun), 1);
    do_reset();
    chk("overrun_cleared", int'(overrun), 0);
    @(negedge clk);
    sample_tick = 1'b1;
    pulses = 0;
    for (int n = 0; n <= 30; n++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      rst = (n == 5);
      if (n == 6) begin
        chk("abort_busy", int'(busy), 0);
        chk("abort_lut_addr", int'(lut_addr), 0);
      end
      if (mix_valid) pulses++;
    end
    chk("abort_no_valid", pulses, 0);
    model_reset();
    run_check("after_abort", 16'h0000, 32'h00000000);
    do_reset();
    cfg_write(2'd0, 16'hFFFF, 3'd6);
    e42[0] = 8'h00; e42[1] = 8'hFF; e42[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      model_sample(em, ea);
      do_sample(lat, mix, a, b0);
      chk($sformatf("wrap%0d_v0_addr", i), int'(a[0]), int'(e42[i]));
      chk($sformatf("wrap%0d_mix", i), int'(mix), int'(em));
    end
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write(2'($urandom_range(0, 3)), 16'($urandom), 3'($urandom_range(0, 7)));
      rom_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      model_sample(em, ea);
      run_check($sformatf("rand%0d", k), em, ea);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
